// File: rtl/request_unit.sv
// request_unit: multicycle fetch/decode/memory sequencer with saturating perf counters
//   CLK, nRST              clock, async active-low reset
//   ihit, iload            instruction memory hit and returned word
//   dhit                   data memory access complete
//   cu_dREN/cu_dWEN/cu_halt control unit decode of the current instruction
//   instruction            latched instruction register
//   imemREN/dmemREN/dmemWEN memory enables (Moore)
//   pc_en                  one-cycle retire pulse (Mealy)
//   halt                   sticky halted flag
//   instr_count/stall_count saturating retired-instruction and stall-cycle counters
module request_unit #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic [31:0]      iload,
  input  logic             dhit,
  input  logic             cu_dREN,
  input  logic             cu_dWEN,
  input  logic             cu_halt,
  output logic [31:0]      instruction,
  output logic             imemREN,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic             pc_en,
  output logic             halt,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] stall_count
);
  typedef enum logic [1:0] {FETCH, DECODE, MEM, HALTED} state_t;
  state_t            r_state, w_next;
  logic [31:0]       r_instr;
  logic              r_wr;
  logic [CNT_W-1:0]  r_icnt, r_scnt;
  logic              w_stall;
  always_comb begin
    w_next  = r_state;
    pc_en   = 1'b0;
    w_stall = 1'b0;
    case (r_state)
      FETCH: begin
        w_next  = ihit ? DECODE : FETCH;
        w_stall = ~ihit;
      end
      DECODE: begin
        w_next = cu_halt ? HALTED : (cu_dWEN | cu_dREN) ? MEM : FETCH;
        pc_en  = ~cu_halt & ~cu_dWEN & ~cu_dREN;
      end
      MEM: begin
        w_next  = dhit ? FETCH : MEM;
        pc_en   = dhit;
        w_stall = ~dhit;
      end
      default: w_next = HALTED;
    endcase
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= FETCH;
      r_instr <= '0;
      r_wr    <= 1'b0;
      r_icnt  <= '0;
      r_scnt  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == FETCH && ihit) r_instr <= iload;
      // write wins when both requests are decoded
      if (r_state == DECODE) r_wr <= cu_dWEN;
      if (pc_en && !(&r_icnt)) r_icnt <= r_icnt + CNT_W'(1);
      if (w_stall && !(&r_scnt)) r_scnt <= r_scnt + CNT_W'(1);
    end
  end
  assign instruction = r_instr;
  assign imemREN     = r_state == FETCH;
  assign dmemREN     = r_state == MEM && !r_wr;
  assign dmemWEN     = r_state == MEM && r_wr;
  assign halt        = r_state == HALTED;
  assign instr_count = r_icnt;
  assign stall_count = r_scnt;
endmodule
